// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - pipelined barrel shifter with valid/ready flow control (optional flags: PIPE_SHIFTER_FLAGS_EN)
`timescale 1ns/1ps
module pipe_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [2:0]                 i_mode,
    input  logic [$clog2(WIDTH)-1:0]   i_sh_amt,
    input  logic [WIDTH-1:0]           i_d_in,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [WIDTH-1:0]           o_d_out
`ifdef PIPE_SHIFTER_FLAGS_EN
    ,
    output logic                       o_z_out,
    output logic                       o_c_out
`endif
);

    localparam int SHW = $clog2(WIDTH);

    // Applies binary-weighted stages lo..hi (stage s has weight 2^(SHW-s), MSB first).
    function automatic logic [WIDTH-1:0] f_shift(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       m,
        input logic [SHW-1:0]   a,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] r;
        int               sh;
        r = d;
        for (int s = 1; s <= SHW; s++) begin
            sh = 1 << (SHW - s);
            if (s >= lo && s <= hi && a[SHW-s]) begin
                case (m)
                    3'b000:  r = r << sh;
                    3'b001:  r = r >> sh;
                    3'b010:  r = $signed(r) >>> sh;
                    3'b011:  r = (r << sh) | (r >> (WIDTH - sh));
                    3'b100:  r = (r >> sh) | (r << (WIDTH - sh));
                    default: r = r;
                endcase
            end
        end
        return r;
    endfunction

`ifdef PIPE_SHIFTER_FLAGS_EN
    // Last bit shifted out; for rotates it equals the bit that wrapped into the far end.
    function automatic logic f_carry(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       m,
        input logic [SHW-1:0]   a
    );
        int   n;
        logic c;
        n = int'(a);
        c = 1'b0;
        if (n != 0) begin
            case (m)
                3'b000, 3'b011:         c = d[WIDTH-n];
                3'b001, 3'b010, 3'b100: c = d[n-1];
                default:                c = 1'b0;
            endcase
        end
        return c;
    endfunction
`endif

    // Index 0 is the input port; index j is slice j feeding slice j+1.
    logic [STAGES-1:0] w_src_vld;
    logic [WIDTH-1:0]  w_src_data [0:STAGES-1];
    logic [2:0]        w_src_mode [0:STAGES-1];
    logic [SHW-1:0]    w_src_amt  [0:STAGES-1];
    logic [STAGES:1]   w_vld;
    logic [STAGES:1]   w_acc;

    assign w_src_vld[0]  = i_in_valid;
    assign w_src_data[0] = i_d_in;
    assign w_src_mode[0] = i_mode;
    assign w_src_amt[0]  = i_sh_amt;
    assign o_in_ready    = w_acc[1];

`ifdef PIPE_SHIFTER_FLAGS_EN
    logic [STAGES-1:0] w_src_c;
    assign w_src_c[0] = f_carry(i_d_in, i_mode, i_sh_amt);
`endif

    for (genvar j = 1; j <= STAGES; j++) begin : g_slice
        localparam int LO = ((j - 1) * SHW + STAGES - 1) / STAGES + 1;
        localparam int HI = (j * SHW + STAGES - 1) / STAGES;

        logic             r_vld;
        logic [WIDTH-1:0] r_data;
        logic [WIDTH-1:0] w_nxt;
        logic             w_load;

        // A slice can take new data unless it and every slice after it are full and the output is stalled.
        assign w_acc[j] = !(&w_vld[STAGES:j]) || i_out_ready;
        assign w_nxt    = f_shift(w_src_data[j-1], w_src_mode[j-1], w_src_amt[j-1], LO, HI);
        assign w_load   = w_acc[j] && w_src_vld[j-1];
        assign w_vld[j] = r_vld;

        // Valid advances whenever the slice accepts, so an empty upstream drains it.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_vld <= 1'b0;
            else if (w_acc[j]) r_vld <= w_src_vld[j-1];
        end

        // Data only moves with a real transfer, keeping stalled output stable.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_data <= '0;
            else if (w_load) r_data <= w_nxt;
        end

`ifdef PIPE_SHIFTER_FLAGS_EN
        logic r_c;
        // Carry is resolved at the input and travels with its transaction.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_c <= 1'b0;
            else if (w_load) r_c <= w_src_c[j-1];
        end
`endif

        if (j < STAGES) begin : g_fwd
            logic [2:0]     r_mode;
            logic [SHW-1:0] r_amt;
            // Control for the stages still to be applied downstream.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_mode <= '0;
                    r_amt  <= '0;
                end else if (w_load) begin
                    r_mode <= w_src_mode[j-1];
                    r_amt  <= w_src_amt[j-1];
                end
            end
            assign w_src_vld[j]  = r_vld;
            assign w_src_data[j] = r_data;
            assign w_src_mode[j] = r_mode;
            assign w_src_amt[j]  = r_amt;
`ifdef PIPE_SHIFTER_FLAGS_EN
            assign w_src_c[j]    = r_c;
`endif
        end else begin : g_out
            assign o_out_valid = r_vld;
            assign o_d_out     = r_data;
`ifdef PIPE_SHIFTER_FLAGS_EN
            logic r_z;
            // Zero flag is taken from the final shifted value as it enters the output register.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) r_z <= 1'b0;
                else if (w_load) r_z <= (w_nxt == '0);
            end
            assign o_z_out = r_z;
            assign o_c_out = r_c;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - self-checking bench for pipe_shifter
`timescale 1ns/1ps
module tb_pipe_shifter;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int SHW    = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       mode = '0;
    logic [SHW-1:0]   sh_amt = '0;
    logic [WIDTH-1:0] d_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] d_out;
`ifdef PIPE_SHIFTER_FLAGS_EN
    logic             z_out;
    logic             c_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH+1:0] exp_q [$];

    pipe_shifter #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_mode      (mode),
        .i_sh_amt    (sh_amt),
        .i_d_in      (d_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_d_out     (d_out)
`ifdef PIPE_SHIFTER_FLAGS_EN
        ,
        .o_z_out     (z_out),
        .o_c_out     (c_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_shift(input logic [2:0] m, input int a, input logic [31:0] d);
        logic [63:0] t;
        logic [31:0] r;
        case (m)
            3'd0: r = d << a;
            3'd1: r = d >> a;
            3'd2: begin t = {{32{d[31]}}, d} >> a; r = t[31:0]; end
            3'd3: begin t = {d, d} << a; r = t[63:32]; end
            3'd4: begin t = {d, d} >> a; r = t[31:0]; end
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic m_carry(input logic [2:0] m, input int a, input logic [31:0] d, input logic [31:0] r);
        if (a == 0 || m > 3'd4) return 1'b0;
        case (m)
            3'd0:       return d[32-a];
            3'd1, 3'd2: return d[a-1];
            3'd3:       return r[0];
            default:    return r[31];
        endcase
    endfunction

    function automatic logic [33:0] m_expect(input logic [2:0] m, input logic [4:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = m_shift(m, int'(a), d);
`ifdef PIPE_SHIFTER_FLAGS_EN
        return {m_carry(m, int'(a), d, r), (r == 32'h0), r};
`else
        return {2'b00, r};
`endif
    endfunction

    function automatic logic [33:0] obs();
`ifdef PIPE_SHIFTER_FLAGS_EN
        return {c_out, z_out, d_out};
`else
        return {2'b00, d_out};
`endif
    endfunction

    // One cycle: drive at the falling edge, sample shortly after; transfers occur at the next rising edge.
    task automatic step(input logic v, input logic [2:0] m, input logic [4:0] a, input logic [31:0] d,
                        input logic ordy, output logic inf, output logic of);
        @(negedge clk);
        in_valid = v; mode = m; sh_amt = a; d_in = d; out_ready = ordy;
        #1;
        inf = v && in_ready;
        of  = out_valid && ordy;
        if (inf) exp_q.push_back(m_expect(m, a, d));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || d_out !== '0) begin
            n_fail++; $display("FAIL reset_hold: valid=%b dout=%h expected 0/0", out_valid, d_out);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_modes();
        logic [31:0] tab [0:4];
        logic inf, of, got;
        logic [33:0] e;
        int lat;
        tab[0] = 32'h0000_0010; tab[1] = 32'h0800_0000; tab[2] = 32'hF800_0000;
        tab[3] = 32'h0000_0018; tab[4] = 32'h1800_0000;
        for (int m = 0; m < 5; m++) begin
            step(1'b1, 3'(m), 5'd4, 32'h8000_0001, 1'b1, inf, of);
            n_checks++;
            if (inf !== 1'b1) begin n_fail++; $display("FAIL mode%0d_accept: in_fire=%b expected 1", m, inf); end
            lat = 0; got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                step(1'b0, 3'd0, 5'd0, 32'h0, 1'b1, inf, of);
                lat++;
                if (of) got = 1'b1;
            end
            n_checks++;
            if (!got || lat != STAGES) begin
                n_fail++; $display("FAIL mode%0d_latency: got=%b cycles=%0d expected %0d", m, got, lat, STAGES);
            end
            n_checks++;
            if (d_out !== tab[m]) begin
                n_fail++; $display("FAIL mode%0d_result: dout=%h expected %h", m, d_out, tab[m]);
            end
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '0;
            n_checks++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL mode%0d_model: obs=%h expected %h", m, obs(), e);
            end
        end
    endtask

`ifdef PIPE_SHIFTER_FLAGS_EN
    task automatic test_flags();
        logic inf, of, got;
        step(1'b1, 3'd1, 5'd2, 32'h0000_0003, 1'b1, inf, of);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step(1'b0, 3'd0, 5'd0, 32'h0, 1'b1, inf, of);
            if (of) got = 1'b1;
        end
        void'(exp_q.pop_front());
        n_checks++;
        if (!got || d_out !== 32'h0 || z_out !== 1'b1 || c_out !== 1'b1) begin
            n_fail++; $display("FAIL flags_srl: got=%b dout=%h z=%b c=%b expected 0/1/1", got, d_out, z_out, c_out);
        end
    endtask
`endif

    task automatic test_boundaries();
        logic [2:0]  bm [0:9];
        logic [4:0]  ba [0:9];
        logic [31:0] bd [0:9];
        logic [31:0] be [0:9];
        logic inf, of, got;
        for (int i = 0; i < 8; i++) begin
            bm[i] = 3'(i); ba[i] = 5'd0; bd[i] = $urandom(); be[i] = bd[i];
        end
        bm[8] = 3'd0; ba[8] = 5'd31; bd[8] = 32'h1; be[8] = 32'h8000_0000;
        bm[9] = 3'd7; ba[9] = 5'($urandom_range(1, 31)); bd[9] = $urandom(); be[9] = bd[9];
        for (int i = 0; i < 10; i++) begin
            step(1'b1, bm[i], ba[i], bd[i], 1'b1, inf, of);
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                step(1'b0, 3'd0, 5'd0, 32'h0, 1'b1, inf, of);
                if (of) got = 1'b1;
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_checks++;
            if (!got || d_out !== be[i]) begin
                n_fail++; $display("FAIL boundary%0d: got=%b dout=%h expected %h", i, got, d_out, be[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic inf, of;
        logic [33:0] e;
        int sent, rcvd;
        sent = 0; rcvd = 0;
        for (int c = 0; c < 8 + STAGES + 4; c++) begin
            step(sent < 8, 3'($urandom_range(0, 4)), 5'($urandom()), $urandom(), 1'b1, inf, of);
            if (sent < 8) begin
                n_checks++;
                if (inf !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d in_ready=%b expected 1", c, in_ready); end
                sent++;
            end
            if (of) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : ~obs();
                n_checks++;
                if (obs() !== e || c != rcvd + STAGES) begin
                    n_fail++; $display("FAIL b2b_out%0d: obs=%h at cycle %0d expected %h at cycle %0d", rcvd, obs(), c, e, rcvd + STAGES);
                end
                rcvd++;
            end
        end
        n_checks++;
        if (rcvd != 8) begin n_fail++; $display("FAIL b2b_count: received %0d expected 8", rcvd); end
    endtask

    task automatic test_backpressure();
        logic inf, of, seen;
        logic [33:0] held, e;
        int acc, rcvd;
        acc = 0; rcvd = 0; seen = 1'b0; held = '0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 5'($urandom()), $urandom(), 1'b0, inf, of);
            if (inf) acc++;
            if (seen) begin
                n_checks++;
                if (obs() !== held || out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL bp_stable: obs=%h valid=%b expected %h/1", obs(), out_valid, held);
                end
            end else if (out_valid) begin
                seen = 1'b1; held = obs();
            end
        end
        n_checks++;
        if (acc != STAGES || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_fill: accepted %0d in_ready=%b expected %0d/0", acc, in_ready, STAGES);
        end
        for (int c = 0; c < 20; c++) begin
            step(c < 3, 3'($urandom_range(0, 7)), 5'($urandom()), $urandom(), 1'b1, inf, of);
            if (inf) acc++;
            if (of) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : ~obs();
                n_checks++;
                if (obs() !== e) begin n_fail++; $display("FAIL bp_out%0d: obs=%h expected %h", rcvd, obs(), e); end
                rcvd++;
            end
        end
        n_checks++;
        if (rcvd != acc || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_count: received %0d expected %0d", rcvd, acc);
        end
    endtask

    task automatic test_random();
        logic inf, of;
        logic [33:0] e;
        logic [31:0] d;
        int errs, outs;
        errs = 0; outs = 0;
        for (int c = 0; c < 600; c++) begin
            d = $urandom();
            if ($urandom_range(0, 7) == 0) d = 32'h0;
            step(c < 560 && $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 5'($urandom()), d,
                 c >= 560 || $urandom_range(0, 9) < 7, inf, of);
            if (of) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : ~obs();
                outs++;
                n_checks++;
                if (obs() !== e) begin
                    errs++; n_fail++;
                    if (errs < 10) $display("FAIL rand_out%0d: obs=%h expected %h", outs, obs(), e);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        logic inf, of;
        int acc;
        acc = 0;
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 3'd0, 5'd1, $urandom() | 32'h1, 1'b0, inf, of);
            if (inf) acc++;
        end
        n_checks++;
        if (acc != 2) begin n_fail++; $display("FAIL rst_mid_fill: accepted %0d expected 2", acc); end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || d_out !== '0) begin
            n_fail++; $display("FAIL rst_mid_clear: valid=%b dout=%h expected 0/0", out_valid, d_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 3'd0, 5'd0, 32'h0, 1'b1, inf, of);
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_after%0d: in_ready=%b out_valid=%b expected 1/0", c, in_ready, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
`ifdef PIPE_SHIFTER_FLAGS_EN
        test_flags();
`endif
        test_boundaries();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
